// File: rtl/i2c_calc_pkg.sv
// Shared types and constants for the I2C target front end of the calculator.
package i2c_calc_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchroniser with edge detect for one I2C line.
// Build option I2C_GLITCH_FILTER_EN inserts a 3-sample majority filter (+2 clk).
module i2c_line_sync
  import i2c_calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] sync;
  logic          clean;
  logic          prev;

  // Idle-high reset so a released bus never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[NS-2:0], pad};
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync[NS-1]};
      filt <= (sync[NS-1] & hist[0]) | (sync[NS-1] & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign clean = filt;
`else
  assign clean = sync[NS-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= clean;
  end

  assign level = clean;
  assign rise  = clean & ~prev;
  assign fall  = ~clean & prev;
endmodule

// File: rtl/i2c_target_if.sv
// Byte-level I2C target: START/STOP detect, address match, write strobes, read shifting.
// Optional glitch filter on both lines via I2C_GLITCH_FILTER_EN (see i2c_line_sync).
//
// state       | meaning
// IDLE        | bus free or not yet addressed
// ADDR        | shifting in address + R/W
// ADDR_ACK    | driving address ACK
// RX_BYTE     | shifting in a write byte
// RX_ACK      | driving data ACK
// TX_BYTE     | driving a read byte, MSB first
// TX_ACK      | sampling master ACK/NACK
// IGNORE      | not addressed / finished; wait for START or STOP
module i2c_target_if
  import i2c_calc_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h2A,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  bus_start,
  output logic                  bus_stop,
  output logic                  selected
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .pad(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .pad(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t            state, state_n;
  logic [I2C_BYTE_W-1:0] shift, shift_n, rx_data_n, new_bit;
  logic [3:0]            cnt, cnt_n;
  logic                  ack_on, ack_on_n, loaded, loaded_n, first, first_n, rw, rw_n;
  logic                  sda_oe_n, rx_valid_n, rx_first_n, tx_req_n;
  logic                  bus_start_n, bus_stop_n, selected_n;
  logic                  start_det, stop_det;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign new_bit   = {shift[I2C_BYTE_W-2:0], sda_lvl};

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    cnt_n       = cnt;
    ack_on_n    = ack_on;
    loaded_n    = loaded;
    first_n     = first;
    rw_n        = rw;
    sda_oe_n    = sda_oe;
    rx_data_n   = rx_data;
    selected_n  = selected;
    rx_valid_n  = 1'b0;
    rx_first_n  = 1'b0;
    tx_req_n    = 1'b0;
    bus_start_n = 1'b0;
    bus_stop_n  = 1'b0;

    if (start_det) begin
      bus_start_n = 1'b1;
      state_n     = ST_ADDR;
      cnt_n       = '0;
      ack_on_n    = 1'b0;
      loaded_n    = 1'b0;
      sda_oe_n    = 1'b0;
      selected_n  = 1'b0;
    end else if (stop_det) begin
      bus_stop_n  = 1'b1;
      state_n     = ST_IDLE;
      sda_oe_n    = 1'b0;
      selected_n  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_n = new_bit;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n    = '0;
            ack_on_n = 1'b0;
            if (new_bit[7:1] == DEV_ADDR && DEV_ADDR != I2C_GEN_CALL) begin
              state_n    = ST_ADDR_ACK;
              selected_n = 1'b1;
              rw_n       = new_bit[0];
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
        // First fall starts the ACK, second fall ends it and begins the data phase.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            ack_on_n = 1'b1;
            sda_oe_n = 1'b1;
          end else begin
            ack_on_n = 1'b0;
            cnt_n    = '0;
            if (rw) begin
              tx_req_n = 1'b1;
              shift_n  = tx_data;
              sda_oe_n = ~tx_data[7];
              loaded_n = 1'b0;
              state_n  = ST_TX_BYTE;
            end else begin
              sda_oe_n = 1'b0;
              first_n  = 1'b1;
              state_n  = ST_RX_BYTE;
            end
          end
        end
        ST_RX_BYTE: if (scl_rise) begin
          shift_n = new_bit;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            rx_data_n  = new_bit;
            rx_valid_n = 1'b1;
            rx_first_n = first;
            first_n    = 1'b0;
            cnt_n      = '0;
            ack_on_n   = 1'b0;
            state_n    = ST_RX_ACK;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          if (!ack_on) begin
            ack_on_n = 1'b1;
            sda_oe_n = 1'b1;
          end else begin
            ack_on_n = 1'b0;
            sda_oe_n = 1'b0;
            state_n  = ST_RX_BYTE;
          end
        end
        // loaded: byte reloaded on an ACK rise, MSB not yet driven.
        ST_TX_BYTE: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (loaded) begin
              sda_oe_n = ~shift[7];
              loaded_n = 1'b0;
            end else if (cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              state_n  = ST_TX_ACK;
            end else begin
              shift_n  = {shift[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end
        ST_TX_ACK: if (scl_rise) begin
          if (!sda_lvl) begin
            tx_req_n = 1'b1;
            shift_n  = tx_data;
            loaded_n = 1'b1;
            cnt_n    = '0;
            state_n  = ST_TX_BYTE;
          end else begin
            selected_n = 1'b0;
            state_n    = ST_IGNORE;
          end
        end
        ST_IGNORE: sda_oe_n = 1'b0;
        default:   state_n  = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      cnt       <= '0;
      ack_on    <= 1'b0;
      loaded    <= 1'b0;
      first     <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_req    <= 1'b0;
      bus_start <= 1'b0;
      bus_stop  <= 1'b0;
      selected  <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      cnt       <= cnt_n;
      ack_on    <= ack_on_n;
      loaded    <= loaded_n;
      first     <= first_n;
      rw        <= rw_n;
      sda_oe    <= sda_oe_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_first  <= rx_first_n;
      tx_req    <= tx_req_n;
      bus_start <= bus_start_n;
      bus_stop  <= bus_stop_n;
      selected  <= selected_n;
    end
  end
endmodule

// File: tb/tb_i2c_target_if.sv
// Scoreboard bench for i2c_target_if: a bus-master model drives SCL/SDA, a monitor checks strobes.
module tb_i2c_target_if;
  localparam int Q = 10;  // clk per SCL quarter period
  localparam int EV_START = 1, EV_STOP = 2, EV_RX = 3, EV_TX = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       first;
  } ev_t;

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [15:0] exp;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, rx_first, tx_req, bus_start, bus_stop, selected;
  logic [7:0] rx_data, tx_data;
  logic [7:0] tx_tab [4] = '{8'h0C, 8'hA5, 8'h3C, 8'h00};
  int         tx_idx = 0;
  int         oe_cnt = 0;
  int         checks = 0, errors = 0;
  logic       done = 1'b0;
  ev_t        exp_q[$];
  obs_t       obs_q[$];

  assign sda_bus = sda_m & ~sda_oe;
  assign tx_data = tx_tab[tx_idx];

  always #5 clk = ~clk;

  i2c_target_if dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .tx_data(tx_data),
    .tx_req(tx_req), .bus_start(bus_start), .bus_stop(bus_stop), .selected(selected)
  );

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic score(input int kind, input logic [7:0] data, input logic first);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual kind=%0d data=%h required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind_%0d", e.kind), 16'(kind), 16'(e.kind));
      if (e.kind == EV_RX) check("rx_data_first", {7'd0, first, data}, {7'd0, e.first, e.data});
    end
  endtask

  always @(negedge clk) begin
    obs_t o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check(o.name, o.act, o.exp);
    end
    if (!rst) begin
      if (sda_oe)    oe_cnt = oe_cnt + 1;
      if (bus_start) score(EV_START, 8'h00, 1'b0);
      if (bus_stop)  score(EV_STOP, 8'h00, 1'b0);
      if (rx_valid)  score(EV_RX, rx_data, rx_first);
      if (tx_req) begin
        score(EV_TX, 8'h00, 1'b0);
        tx_idx = tx_idx + 1;
      end
    end
    if (done) begin
      check("events_left", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master model ----------------
  function automatic void expect_obs(input string n, input logic [15:0] a, input logic [15:0] e);
    obs_t o;
    o.name = n; o.act = a; o.exp = e;
    obs_q.push_back(o);
  endfunction

  function automatic void expect_ev(input int kind, input logic [7:0] data, input logic first);
    ev_t e;
    e.kind = kind; e.data = data; e.first = first;
    exp_q.push_back(e);
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq(Q); scl_m = 1'b1; wq(2 * Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic glitch_bit(input logic b);
    sda_m = b; wq(Q); scl_m = 1'b1; wq(Q);
    scl_m = 1'b0; wq(1); scl_m = 1'b1; wq(Q - 1);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); b = sda_bus; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  logic       ack;
  logic [7:0] rd;
  logic [2:0] bits3;
  int         oe0;

  initial begin
    wq(5);
    expect_obs("rst_sda_oe", 16'(sda_oe), 16'd0);
    expect_obs("rst_rx_valid", 16'(rx_valid), 16'd0);
    expect_obs("rst_rx_first", 16'(rx_first), 16'd0);
    expect_obs("rst_rx_data", 16'(rx_data), 16'd0);
    expect_obs("rst_tx_req", 16'(tx_req), 16'd0);
    expect_obs("rst_bus_start", 16'(bus_start), 16'd0);
    expect_obs("rst_bus_stop", 16'(bus_stop), 16'd0);
    expect_obs("rst_selected", 16'(selected), 16'd0);
    rst = 1'b0;
    wq(20);

    // write 0x05, 0x07 to 0x2A
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_RX, 8'h05, 1'b1);
    expect_ev(EV_RX, 8'h07, 1'b0);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h54, ack); expect_obs("w_addr_ack", 16'(ack), 16'd0);
    expect_obs("w_selected", 16'(selected), 16'd1);
    write_byte(8'h05, ack); expect_obs("w_d0_ack", 16'(ack), 16'd0);
    write_byte(8'h07, ack); expect_obs("w_d1_ack", 16'(ack), 16'd0);
    i2c_stop();
    expect_obs("w_sel_after_stop", 16'(selected), 16'd0);

    // wrong address 0x2B
    oe0 = oe_cnt;
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h56, ack); expect_obs("n_addr_nack", 16'(ack), 16'd1);
    expect_obs("n_selected", 16'(selected), 16'd0);
    i2c_stop();
    expect_obs("n_sda_oe_cycles", 16'(oe_cnt - oe0), 16'd0);

    // read 0x0C (ACK), 0xA5 (NACK)
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_TX, 8'h00, 1'b0);
    expect_ev(EV_TX, 8'h00, 1'b0);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h55, ack); expect_obs("r_addr_ack", 16'(ack), 16'd0);
    read_byte(rd, 1'b0); expect_obs("r_byte0", 16'(rd), 16'h0C);
    read_byte(rd, 1'b1); expect_obs("r_byte1", 16'(rd), 16'hA5);
    wq(Q);
    expect_obs("r_sel_after_nack", 16'(selected), 16'd0);
    i2c_stop();

    // write 0x03, repeated START, read 0x3C
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_RX, 8'h03, 1'b1);
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_TX, 8'h00, 1'b0);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h54, ack); expect_obs("rs_waddr_ack", 16'(ack), 16'd0);
    write_byte(8'h03, ack); expect_obs("rs_d0_ack", 16'(ack), 16'd0);
    i2c_start();
    write_byte(8'h55, ack); expect_obs("rs_raddr_ack", 16'(ack), 16'd0);
    read_byte(rd, 1'b1); expect_obs("rs_rbyte", 16'(rd), 16'h3C);
    i2c_stop();

    // reset during bit 4 of a read byte (core byte 0x00 -> SDA pulled low)
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_TX, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h55, ack); expect_obs("rr_addr_ack", 16'(ack), 16'd0);
    for (int i = 2; i >= 0; i--) read_bit(bits3[i]);
    expect_obs("rr_bits765", 16'(bits3), 16'd0);
    wq(Q);
    expect_obs("rr_b4_driven", 16'(sda_oe), 16'd1);
    rst = 1'b1; wq(1); rst = 1'b0;
    expect_obs("rr_oe_after_rst", 16'(sda_oe), 16'd0);
    expect_obs("rr_sel_after_rst", 16'(selected), 16'd0);
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(4 * Q);

    // fresh write after reset
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_RX, 8'h81, 1'b1);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h54, ack); expect_obs("pr_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h81, ack); expect_obs("pr_d0_ack", 16'(ack), 16'd0);
    i2c_stop();

`ifdef I2C_GLITCH_FILTER_EN
    // 1-clk SCL low glitch inside bit 3 must be rejected
    expect_ev(EV_START, 8'h00, 1'b0);
    expect_ev(EV_RX, 8'h5A, 1'b1);
    expect_ev(EV_STOP, 8'h00, 1'b0);
    i2c_start();
    write_byte(8'h54, ack); expect_obs("g_addr_ack", 16'(ack), 16'd0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) glitch_bit(rd[0] ^ rd[0] ^ 1'b1);
      else        write_bit(i == 6 || i == 4 || i == 1);
    end
    read_bit(ack); expect_obs("g_d0_ack", 16'(ack), 16'd0);
    i2c_stop();
`endif

    wq(4 * Q);
    done = 1'b1;
  end
endmodule
